// File: rtl/matvec_sequencer.sv
// Command-driven sequencer for one matrix-vector multiply on a PE_NUMBER-wide
// systolic array. Loads the vector and matrix into the operand RAM, issues
// skewed per-PE fetch addresses, writes the drained results back to RAM and
// streams them out on a valid/ready result channel.
module matvec_sequencer #(
  parameter int          ADDR_SIZE = 10,
  parameter int          WORD_SIZE = 16,
  parameter int          PE_NUMBER = 64,
  parameter logic [15:0] BASE_ADDR = 16'h000f,
  parameter logic [15:0] ZERO_ADDR = 16'hffff,
  parameter int          ARRAY_LAT = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [3:0]                     cmd_op,
  input  logic [WORD_SIZE-1:0]           cmd_data,
  output logic                           mem_w_en,
  output logic [ADDR_SIZE-1:0]           mem_w_addr,
  output logic [WORD_SIZE-1:0]           mem_w_data,
  output logic [ADDR_SIZE-1:0]           mem_r_addr,
  input  logic [WORD_SIZE-1:0]           mem_r_data,
  output logic [ADDR_SIZE-1:0]           vec_addr,
  output logic [PE_NUMBER*ADDR_SIZE-1:0] pe_addr,
  output logic                           arr_clear,
  output logic                           arr_read,
  input  logic [WORD_SIZE-1:0]           arr_result,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [WORD_SIZE-1:0]           res_data,
  output logic                           busy,
  output logic                           err
);

  localparam logic [ADDR_SIZE-1:0] BASE_A     = BASE_ADDR[ADDR_SIZE-1:0];
  localparam logic [ADDR_SIZE-1:0] ZERO_A     = ZERO_ADDR[ADDR_SIZE-1:0];
  localparam logic [ADDR_SIZE-1:0] A_ONE      = ADDR_SIZE'(1);
  localparam logic [31:0]          ADDR_SPACE = 32'(1) << ADDR_SIZE;

  localparam logic [3:0] OP_SET_ROWS = 4'd1;
  localparam logic [3:0] OP_SET_COLS = 4'd2;
  localparam logic [3:0] OP_START    = 4'd3;
  localparam logic [3:0] OP_WR_VEC   = 4'd4;
  localparam logic [3:0] OP_WR_MAT   = 4'd5;
  localparam logic [3:0] OP_RD_RES   = 4'd6;
  localparam logic [3:0] OP_CLR_ERR  = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_LD_VEC, S_LD_MAT, S_FETCH, S_DRAIN, S_WRITEBACK, S_WB_CLEAR, S_READOUT
  } state_t;

  state_t                 state_reg;
  logic [7:0]             rows_reg;
  logic [7:0]             cols_reg;
  logic                   err_reg;
  logic [15:0]            ld_cnt_reg;
  logic [ADDR_SIZE-1:0]   ld_addr_reg;
  logic [8:0]             t_cnt_reg;
  logic [ADDR_SIZE-1:0]   row_base_reg;
  logic [7:0]             drain_cnt_reg;
  logic [7:0]             wb_cnt_reg;
  logic [7:0]             rd_idx_reg;
  logic                   rd_phase_reg;
  logic [ADDR_SIZE-1:0]   rd_addr_reg;
  logic                   res_valid_reg;
  logic [WORD_SIZE-1:0]   res_data_reg;

  logic [15:0]            rc_prod;
  logic [ADDR_SIZE-1:0]   mat_base;
  logic [ADDR_SIZE-1:0]   res_base;
  logic [31:0]            cfg_need;
  logic                   cfg_bad;
  logic                   fetch_last;
  logic [15:0]            ld_target;
  logic                   ld_last;
  logic                   in_load;

  // Layout bases and the START-time configuration sanity check
  assign rc_prod    = 16'(rows_reg) * 16'(cols_reg);
  assign mat_base   = BASE_A + ADDR_SIZE'(rows_reg);
  assign res_base   = mat_base + ADDR_SIZE'(rc_prod);
  assign cfg_need   = 32'(rows_reg) + 32'(rc_prod) + 32'(cols_reg) + 32'(BASE_ADDR);
  assign cfg_bad    = (rows_reg == 8'd0) || (cols_reg == 8'd0) ||
                      (32'(cols_reg) > 32'(PE_NUMBER)) || (cfg_need > ADDR_SPACE);
  assign fetch_last = (t_cnt_reg == 9'(rows_reg) + 9'(cols_reg) - 9'd2);
  assign in_load    = (state_reg == S_LD_VEC) || (state_reg == S_LD_MAT);
  assign ld_target  = (state_reg == S_LD_VEC) ? 16'(rows_reg) : rc_prod;
  assign ld_last    = (ld_cnt_reg == ld_target - 16'd1);

  assign cmd_ready  = (state_reg == S_IDLE) || in_load;
  assign arr_read   = (state_reg == S_WRITEBACK);
  assign arr_clear  = !((state_reg == S_FETCH) || (state_reg == S_DRAIN) ||
                        (state_reg == S_WRITEBACK));
  assign busy       = (state_reg != S_IDLE);
  assign err        = err_reg;
  assign mem_r_addr = rd_addr_reg;
  assign res_valid  = res_valid_reg;
  assign res_data   = res_data_reg;

  assign vec_addr = ((state_reg == S_FETCH) && (32'(t_cnt_reg) < 32'(rows_reg)))
                    ? BASE_A + ADDR_SIZE'(t_cnt_reg) : ZERO_A;

  // Lane i reads row k=t-i; row_base tracks mat_base+t*C so the lane offset is -i*(C-1).
  // Unsigned wrap of t-i makes the "t<i" case fall outside the row range.
  for (genvar gi = 0; gi < PE_NUMBER; gi++) begin : g_lane
    localparam logic [31:0] LANE = 32'(gi);
    logic                 lane_on;
    logic [ADDR_SIZE-1:0] lane_addr;
    assign lane_on   = (state_reg == S_FETCH) && (LANE < 32'(cols_reg)) &&
                       ((32'(t_cnt_reg) - LANE) < 32'(rows_reg));
    assign lane_addr = row_base_reg - ADDR_SIZE'(LANE * 32'(cols_reg)) + ADDR_SIZE'(LANE);
    assign pe_addr[gi*ADDR_SIZE +: ADDR_SIZE] = lane_on ? lane_addr : ZERO_A;
  end

  // RAM write port: operand words on accept during loads, array results during writeback
  always_comb begin
    mem_w_en   = 1'b0;
    mem_w_addr = '0;
    mem_w_data = '0;
    if (in_load && cmd_valid) begin
      mem_w_en   = 1'b1;
      mem_w_addr = ld_addr_reg;
      mem_w_data = cmd_data;
    end else if (state_reg == S_WRITEBACK) begin
      mem_w_en   = 1'b1;
      mem_w_addr = res_base + ADDR_SIZE'(wb_cnt_reg);
      mem_w_data = arr_result;
    end
  end

  // Main sequencer FSM with its counters and the registered result channel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      rows_reg      <= '0;
      cols_reg      <= '0;
      err_reg       <= 1'b0;
      ld_cnt_reg    <= '0;
      ld_addr_reg   <= '0;
      t_cnt_reg     <= '0;
      row_base_reg  <= '0;
      drain_cnt_reg <= '0;
      wb_cnt_reg    <= '0;
      rd_idx_reg    <= '0;
      rd_phase_reg  <= 1'b0;
      rd_addr_reg   <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_SET_ROWS: rows_reg <= cmd_data[7:0];
              OP_SET_COLS: cols_reg <= cmd_data[7:0];
              OP_CLR_ERR:  err_reg  <= 1'b0;
              OP_START: begin
                if (cfg_bad) begin
                  err_reg <= 1'b1;
                end else begin
                  state_reg    <= S_FETCH;
                  t_cnt_reg    <= '0;
                  row_base_reg <= mat_base;
                end
              end
              OP_WR_VEC: begin
                if (rows_reg == 8'd0) begin
                  err_reg <= 1'b1;
                end else begin
                  state_reg   <= S_LD_VEC;
                  ld_addr_reg <= BASE_A;
                  ld_cnt_reg  <= '0;
                end
              end
              OP_WR_MAT: begin
                if (rc_prod == 16'd0) begin
                  err_reg <= 1'b1;
                end else begin
                  state_reg   <= S_LD_MAT;
                  ld_addr_reg <= mat_base;
                  ld_cnt_reg  <= '0;
                end
              end
              OP_RD_RES: begin
                if (cols_reg == 8'd0) begin
                  err_reg <= 1'b1;
                end else begin
                  state_reg     <= S_READOUT;
                  rd_idx_reg    <= '0;
                  rd_phase_reg  <= 1'b0;
                  rd_addr_reg   <= res_base;
                  res_valid_reg <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        S_LD_VEC, S_LD_MAT: begin
          if (cmd_valid) begin
            ld_addr_reg <= ld_addr_reg + A_ONE;
            ld_cnt_reg  <= ld_cnt_reg + 16'd1;
            if (ld_last) state_reg <= S_IDLE;
          end
        end
        S_FETCH: begin
          t_cnt_reg    <= t_cnt_reg + 9'd1;
          row_base_reg <= row_base_reg + ADDR_SIZE'(cols_reg);
          if (fetch_last) begin
            state_reg     <= S_DRAIN;
            drain_cnt_reg <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_cnt_reg == 8'(ARRAY_LAT - 1)) begin
            state_reg  <= S_WRITEBACK;
            wb_cnt_reg <= '0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 8'd1;
          end
        end
        S_WRITEBACK: begin
          wb_cnt_reg <= wb_cnt_reg + 8'd1;
          if (wb_cnt_reg == cols_reg - 8'd1) state_reg <= S_WB_CLEAR;
        end
        S_WB_CLEAR: state_reg <= S_IDLE;
        S_READOUT: begin
          // The next address is issued as soon as a word is captured, so after a
          // handshake the following word is already on mem_r_data: one bubble.
          if (!res_valid_reg) begin
            if (!rd_phase_reg) begin
              rd_phase_reg <= 1'b1;
            end else begin
              res_data_reg  <= mem_r_data;
              res_valid_reg <= 1'b1;
              rd_addr_reg   <= rd_addr_reg + A_ONE;
            end
          end else if (res_ready) begin
            res_valid_reg <= 1'b0;
            if (rd_idx_reg == cols_reg - 8'd1) state_reg <= S_IDLE;
            else rd_idx_reg <= rd_idx_reg + 8'd1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
